// File: rtl/conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_layer_sequencer
//  Description : Steps a convolution window across an IMG_H x IMG_W input.
//                For each window it pulses the conv unit reset, then holds it
//                out of reset for MAC_CYCLES cycles. On the last accumulate
//                cycle it captures the unit result and the row-major output
//                index, and offers them downstream with a valid/ready
//                handshake. One done pulse marks the end of each pass.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_layer_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int F          = 3,
    parameter int IMG_W      = 5,
    parameter int IMG_H      = 5,
    localparam int OUT_W      = IMG_W - F + 1,
    localparam int OUT_H      = IMG_H - F + 1,
    localparam int MAC_CYCLES = D * F * F + 2,
    localparam int ADDR_W     = (OUT_W * OUT_H > 1) ? $clog2(OUT_W * OUT_H) : 1,
    localparam int ROW_W      = (IMG_H > 1) ? $clog2(IMG_H) : 1,
    localparam int COL_W      = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  unit_reset,
    output logic [ROW_W-1:0]      win_row,
    output logic [COL_W-1:0]      win_col,
    input  logic [DATA_WIDTH-1:0] unit_result,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_W-1:0]     out_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    // Accumulate counter only has to reach MAC_CYCLES-1.
    localparam int c_CNT_W = (MAC_CYCLES > 1) ? $clog2(MAC_CYCLES) : 1;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CLEAR = 3'd1;
    localparam logic [2:0] c_ST_ACCUM = 3'd2;
    localparam logic [2:0] c_ST_EMIT  = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAC_CYCLES - 1);
    localparam logic [ROW_W-1:0]   c_ROW_LAST = ROW_W'(OUT_H - 1);
    localparam logic [COL_W-1:0]   c_COL_LAST = COL_W'(OUT_W - 1);

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [ROW_W-1:0]      r_win_row;
    logic [COL_W-1:0]      r_win_col;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [ADDR_W-1:0]     r_out_addr;

    logic                  w_handshake;
    logic                  w_last_win;
    logic                  w_accum_last;
    logic [ADDR_W-1:0]     w_win_addr;

    assign w_handshake  = (r_state == c_ST_EMIT) && out_ready;
    assign w_last_win   = (r_win_row == c_ROW_LAST) && (r_win_col == c_COL_LAST);
    assign w_accum_last = (r_state == c_ST_ACCUM) && (r_cnt == c_CNT_LAST);

    // Row-major index of the window currently being computed.
    assign w_win_addr = ADDR_W'(r_win_row) * ADDR_W'(OUT_W) + ADDR_W'(r_win_col);

    // Next-state decode; start is only looked at while idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_CLEAR;
                end
            end
            c_ST_CLEAR: begin
                w_state_nxt = c_ST_ACCUM;
            end
            c_ST_ACCUM: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_ST_EMIT;
                end
            end
            c_ST_EMIT: begin
                if (out_ready) begin
                    w_state_nxt = w_last_win ? c_ST_DONE : c_ST_CLEAR;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulate cycle counter: zero outside ACCUM, saturates on the last cycle
    // so it can never wrap inside a window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state != c_ST_ACCUM) begin
            r_cnt <= '0;
        end else if (r_cnt != c_CNT_LAST) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Window position advances only when an output is accepted; after the last
    // window it wraps to the origin, so it is already zero back in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_row <= '0;
            r_win_col <= '0;
        end else if (w_handshake) begin
            if (r_win_col != c_COL_LAST) begin
                r_win_col <= r_win_col + COL_W'(1);
            end else begin
                r_win_col <= '0;
                if (w_last_win) begin
                    r_win_row <= '0;
                end else begin
                    r_win_row <= r_win_row + ROW_W'(1);
                end
            end
        end
    end

    // Capture result and index on the final accumulate cycle; both then hold
    // for as long as the downstream stalls in EMIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_data <= '0;
            r_out_addr <= '0;
        end else if (w_accum_last) begin
            r_out_data <= unit_result;
            r_out_addr <= w_win_addr;
        end
    end

    assign unit_reset = (r_state == c_ST_IDLE) || (r_state == c_ST_CLEAR) ||
                        (r_state == c_ST_DONE);
    assign out_valid  = (r_state == c_ST_EMIT);
    assign busy       = (r_state != c_ST_IDLE);
    assign done       = (r_state == c_ST_DONE);
    assign win_row    = r_win_row;
    assign win_col    = r_win_col;
    assign out_data   = r_out_data;
    assign out_addr   = r_out_addr;

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_layer_sequencer
//  Description : Self-checking bench for conv_layer_sequencer with a tagging
//                conv-unit model and a row-major output scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_layer_sequencer;

    localparam int OUT_W = 3;
    localparam int N_OUT = 9;
    localparam int MAC   = 11;
    localparam int WIN_T = MAC + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        out_ready;
    logic        unit_reset;
    logic [2:0]  win_row;
    logic [2:0]  win_col;
    logic [15:0] unit_result;
    logic [15:0] out_data;
    logic [3:0]  out_addr;
    logic        out_valid;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    conv_layer_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .unit_reset  (unit_reset),
        .win_row     (win_row),
        .win_col     (win_col),
        .unit_result (unit_result),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    // Conv unit model: counts its out-of-reset cycles and tags the result with
    // that count and the window coordinate.
    int lowcnt;
    always @(posedge clk or posedge reset) begin
        if (reset)           lowcnt <= 0;
        else if (unit_reset) lowcnt <= 0;
        else                 lowcnt <= lowcnt + 1;
    end
    assign unit_result = 16'h3C00 + 16'(int'(win_row) * OUT_W + int'(win_col))
                       + 16'((lowcnt + 1) * 256);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] exp_tag(input int a);
        return 16'h3C00 + 16'(a) + 16'(MAC * 256);
    endfunction

    // Scoreboard state
    bit          mon_en = 1'b0;
    int          exp_addr = 0;
    int          hs_total = 0;
    int          done_total = 0;
    int          done_cyc = 0;
    bit          pend_done = 1'b0;
    bit          pend_idle = 1'b0;
    bit          prev_valid = 1'b0;
    bit          prev_ready = 1'b0;
    logic [15:0] prev_data = '0;
    logic [3:0]  prev_addr = '0;
    int          rise_q[$];

    // Output monitor, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !reset) begin
                check_eq("win_pos", 32'({win_row, win_col}),
                         32'({3'(exp_addr / OUT_W), 3'(exp_addr % OUT_W)}));
                if (prev_valid && !prev_ready) begin
                    check_eq("hold_valid", 32'(out_valid), 32'(1));
                    check_eq("hold_data", 32'(out_data), 32'(prev_data));
                    check_eq("hold_addr", 32'(out_addr), 32'(prev_addr));
                end
                if (out_valid) begin
                    if (!prev_valid) rise_q.push_back(cyc);
                    check_eq("out_data", 32'(out_data), 32'(exp_tag(exp_addr)));
                    check_eq("out_addr", 32'(out_addr), 32'(exp_addr));
                    check_eq("ureset_emit", 32'(unit_reset), 32'(0));
                end
                check_eq("done", 32'(done), 32'(pend_done));
                if (pend_idle) check_eq("busy_after_done", 32'(busy), 32'(0));
                if (done) begin
                    done_total++;
                    done_cyc = cyc;
                end
                pend_idle = pend_done;
                pend_done = 1'b0;
                if (out_valid && out_ready) begin
                    hs_total++;
                    if (exp_addr == N_OUT - 1) begin
                        exp_addr  = 0;
                        pend_done = 1'b1;
                    end else begin
                        exp_addr++;
                    end
                end
                prev_valid = out_valid;
                prev_ready = out_ready;
                prev_data  = out_data;
                prev_addr  = out_addr;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    int kick_cyc;
    int hs0;
    int d0;
    int dc1;
    int n;

    task automatic kick();
        @(posedge clk); #1;
        start    = 1'b1;
        kick_cyc = cyc;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input bit rr, input bit rs);
        int k = 0;
        while (done_total < target && k < budget) begin
            @(posedge clk); #1;
            k++;
            if (rr) out_ready = ($urandom_range(0, 3) != 0);
            if (rs) start = (unit_reset == 1'b0) && ($urandom_range(0, 2) == 0);
        end
        if (rs) start = 1'b0;
        out_ready = 1'b1;
        check_eq("pass_complete", 32'(done_total >= target), 32'(1));
    endtask

    task automatic idle_check(input string t, input int cycles);
        int h = hs_total;
        int d = done_total;
        repeat (cycles) @(posedge clk);
        #1;
        check_eq({t, "_busy_idle"}, 32'(busy), 32'(0));
        check_eq({t, "_no_extra_out"}, 32'(hs_total), 32'(h));
        check_eq({t, "_no_extra_done"}, 32'(done_total), 32'(d));
    endtask

    task automatic check_reset_vals(input string t);
        check_eq({t, "_unit_reset"}, 32'(unit_reset), 32'(1));
        check_eq({t, "_win"}, 32'({win_row, win_col}), 32'(0));
        check_eq({t, "_out_data"}, 32'(out_data), 32'(0));
        check_eq({t, "_out_addr"}, 32'(out_addr), 32'(0));
        check_eq({t, "_out_valid"}, 32'(out_valid), 32'(0));
        check_eq({t, "_busy"}, 32'(busy), 32'(0));
        check_eq({t, "_done"}, 32'(done), 32'(0));
    endtask

    task automatic model_reinit();
        exp_addr   = 0;
        pend_done  = 1'b0;
        pend_idle  = 1'b0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        rise_q.delete();
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("por");
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Nominal pass, ready always high: latency and window spacing.
        rise_q.delete();
        hs0 = hs_total; d0 = done_total;
        kick();
        wait_done(d0 + 1, 400, 1'b0, 1'b0);
        check_eq("t1_outputs", 32'(hs_total - hs0), 32'(N_OUT));
        check_eq("t1_rises", 32'(rise_q.size()), 32'(N_OUT));
        if (rise_q.size() == N_OUT) begin
            check_eq("t1_first_valid", 32'(rise_q[0] - kick_cyc), 32'(WIN_T));
            for (int i = 1; i < N_OUT; i++)
                check_eq("t1_spacing", 32'(rise_q[i] - rise_q[i-1]), 32'(WIN_T));
            check_eq("t1_done_lat", 32'(done_cyc - rise_q[N_OUT-1]), 32'(1));
        end
        idle_check("t1", 3);

        // Backpressure for 20 cycles on output 4.
        hs0 = hs_total; d0 = done_total;
        kick();
        n = 0;
        while (!(out_valid && out_addr == 4'd4) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("t3_reach_out4", 32'(out_valid && out_addr == 4'd4), 32'(1));
        out_ready = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            check_eq("t3_valid_held", 32'(out_valid), 32'(1));
            check_eq("t3_win_frozen", 32'({win_row, win_col}), 32'({3'd1, 3'd1}));
            check_eq("t3_unit_reset", 32'(unit_reset), 32'(0));
        end
        out_ready = 1'b1;
        wait_done(d0 + 1, 400, 1'b0, 1'b0);
        check_eq("t3_outputs", 32'(hs_total - hs0), 32'(N_OUT));
        idle_check("t3", 3);

        // Random ready and spurious start pulses during ACCUM/EMIT.
        for (int p = 0; p < 3; p++) begin
            hs0 = hs_total; d0 = done_total;
            kick();
            wait_done(d0 + 1, 3000, 1'b1, 1'b1);
            check_eq("rnd_outputs", 32'(hs_total - hs0), 32'(N_OUT));
            idle_check("rnd", 4);
        end

        // Reset during ACCUM of window 5, then restart on the release edge.
        kick();
        n = 0;
        while (!(exp_addr == 5 && unit_reset == 1'b0 && !out_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("t5_reach_win5", 32'(exp_addr == 5 && unit_reset == 1'b0), 32'(1));
        repeat (3) @(posedge clk);
        #3;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check_reset_vals("t5_async");
        repeat (2) @(posedge clk);
        #1;
        check_eq("t5_held_valid", 32'(out_valid), 32'(0));
        model_reinit();
        hs0 = hs_total; d0 = done_total;
        @(posedge clk); #1;
        reset    = 1'b0;
        start    = 1'b1;
        kick_cyc = cyc;
        mon_en   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(d0 + 1, 400, 1'b0, 1'b0);
        check_eq("t5_outputs", 32'(hs_total - hs0), 32'(N_OUT));
        if (rise_q.size() > 0)
            check_eq("t5_first_valid", 32'(rise_q[0] - kick_cyc), 32'(WIN_T));
        idle_check("t5", 3);

        // Start held high: back-to-back passes.
        rise_q.delete();
        hs0 = hs_total; d0 = done_total;
        @(posedge clk); #1;
        start = 1'b1;
        wait_done(d0 + 1, 400, 1'b0, 1'b0);
        dc1 = done_cyc;
        wait_done(d0 + 2, 400, 1'b0, 1'b0);
        start = 1'b0;
        check_eq("t6_outputs", 32'(hs_total - hs0), 32'(2 * N_OUT));
        check_eq("t6_rises", 32'(rise_q.size()), 32'(2 * N_OUT));
        if (rise_q.size() == 2 * N_OUT)
            check_eq("t6_restart_gap", 32'(rise_q[N_OUT] - dc1), 32'(WIN_T + 1));
        idle_check("t6", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
